// File: rtl/rr_grant_index_arbiter.sv
// rtl/rr_grant_index_arbiter.sv - round-robin arbiter emitting a registered binary grant index with valid/ready
// Optional feature macro: RR_ARB_GRANT_LOCK_EN (adds lock input to repeat the current winner)
module rr_grant_index_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int IDX_WIDTH = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req,
`ifdef RR_ARB_GRANT_LOCK_EN
    input  logic                 lock,
`endif
    input  logic                 gnt_ready,
    output logic                 gnt_valid,
    output logic [IDX_WIDTH-1:0] gnt_idx
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t                 state;
    logic [IDX_WIDTH-1:0]   ptr;
    logic [IDX_WIDTH-1:0]   adv_ptr;
    logic [IDX_WIDTH-1:0]   base;
    logic [IDX_WIDTH-1:0]   sel;
    logic                   hold;
    logic [2*NUM_REQ-1:0]   dbl;
    logic [NUM_REQ-1:0]     rot;
    logic                   found;
    int                     pos;

    always_comb begin
`ifdef RR_ARB_GRANT_LOCK_EN
        hold = lock && req[gnt_idx];
`else
        hold = 1'b0;
`endif
    end

    // Pointer the handshake would commit; selection in GRANT already uses it
    // so back-to-back grants honour the rotated priority.
    always_comb begin
        if (hold) begin
            adv_ptr = gnt_idx;
        end else if (gnt_idx == IDX_WIDTH'(NUM_REQ - 1)) begin
            adv_ptr = '0;
        end else begin
            adv_ptr = gnt_idx + IDX_WIDTH'(1);
        end
        base = (state == GRANT) ? adv_ptr : ptr;
    end

    always_comb begin
        dbl   = {req, req} >> base;
        rot   = dbl[NUM_REQ-1:0];
        sel   = '0;
        found = 1'b0;
        pos   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                pos   = int'(base) + k;
                if (pos >= NUM_REQ) begin
                    pos = pos - NUM_REQ;
                end
                sel = IDX_WIDTH'(pos);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
        end else if (state == IDLE) begin
            if (|req) begin
                gnt_idx   <= sel;
                gnt_valid <= 1'b1;
                state     <= GRANT;
            end
        end else begin
            if (gnt_ready) begin
                ptr <= adv_ptr;
                if (|req) begin
                    gnt_idx <= sel;
                end else begin
                    gnt_valid <= 1'b0;
                    state     <= IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_rr_grant_index_arbiter.sv
// tb/tb_rr_grant_index_arbiter.sv - self-checking bench for rr_grant_index_arbiter (4- and 3-requester instances)
module tb_rr_grant_index_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = '0;
    logic       gnt_ready = 1'b0;
    logic       gnt_valid;
    logic [1:0] gnt_idx;
    logic [2:0] req3 = '0;
    logic       rdy3 = 1'b0;
    logic       v3;
    logic [1:0] idx3;
    logic       lock = 1'b0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rr_grant_index_arbiter #(.NUM_REQ(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .req(req),
`ifdef RR_ARB_GRANT_LOCK_EN
        .lock(lock),
`endif
        .gnt_ready(gnt_ready), .gnt_valid(gnt_valid), .gnt_idx(gnt_idx)
    );

    rr_grant_index_arbiter #(.NUM_REQ(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .req(req3),
`ifdef RR_ARB_GRANT_LOCK_EN
        .lock(lock),
`endif
        .gnt_ready(rdy3), .gnt_valid(v3), .gnt_idx(idx3)
    );

    typedef struct packed {
        logic [3:0] req;
        logic       rdy;
        logic       exp_valid;
        logic [1:0] exp_idx;
    } vec_t;

    vec_t tbl [21];

    int  m_ptr [2];
    int  m_idx [2];
    bit  m_val [2];
    int  m_n   [2];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic int pick_ref(input int rmask, input int p, input int n);
        for (int k = 0; k < n; k++) begin
            if (((rmask >> ((p + k) % n)) & 1) != 0) return (p + k) % n;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_ptr[d] = 0;
            m_idx[d] = 0;
            m_val[d] = 1'b0;
        end
    endtask

    // Behaviour of one clock edge given this cycle's inputs.
    task automatic model_step(input int d, input int rmask, input bit rdy, input bit lk);
        int n;
        n = m_n[d];
        if (!m_val[d]) begin
            if (rmask != 0) begin
                m_idx[d] = pick_ref(rmask, m_ptr[d], n);
                m_val[d] = 1'b1;
            end
        end else if (rdy) begin
            if (lk && (((rmask >> m_idx[d]) & 1) != 0)) m_ptr[d] = m_idx[d];
            else m_ptr[d] = (m_idx[d] + 1) % n;
            if (rmask != 0) m_idx[d] = pick_ref(rmask, m_ptr[d], n);
            else m_val[d] = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        int exp3 [4];
        bit lk;
        m_n[0] = 4;
        m_n[1] = 3;

        tbl[0]  = '{4'b1111, 1'b0, 1'b1, 2'd0};
        tbl[1]  = '{4'b1111, 1'b1, 1'b1, 2'd1};
        tbl[2]  = '{4'b1111, 1'b1, 1'b1, 2'd2};
        tbl[3]  = '{4'b1111, 1'b1, 1'b1, 2'd3};
        tbl[4]  = '{4'b1111, 1'b1, 1'b1, 2'd0};
        tbl[5]  = '{4'b1111, 1'b1, 1'b1, 2'd1};
        tbl[6]  = '{4'b0000, 1'b1, 1'b0, 2'd0};
        tbl[7]  = '{4'b0100, 1'b0, 1'b1, 2'd2};
        tbl[8]  = '{4'b0000, 1'b1, 1'b0, 2'd0};
        tbl[9]  = '{4'b0001, 1'b0, 1'b1, 2'd0};
        tbl[10] = '{4'b0000, 1'b1, 1'b0, 2'd0};
        tbl[11] = '{4'b1010, 1'b0, 1'b1, 2'd1};
        tbl[12] = '{4'b1010, 1'b0, 1'b1, 2'd1};
        tbl[13] = '{4'b1010, 1'b0, 1'b1, 2'd1};
        tbl[14] = '{4'b1010, 1'b0, 1'b1, 2'd1};
        tbl[15] = '{4'b1010, 1'b0, 1'b1, 2'd1};
        tbl[16] = '{4'b1000, 1'b0, 1'b1, 2'd1};
        tbl[17] = '{4'b1000, 1'b1, 1'b1, 2'd3};
        tbl[18] = '{4'b0000, 1'b1, 1'b0, 2'd0};
        tbl[19] = '{4'b0000, 1'b1, 1'b0, 2'd0};
        tbl[20] = '{4'b0010, 1'b1, 1'b1, 2'd1};

        // Reset held with all requests pending
        req = 4'b1111;
        rst_n = 1'b0;
        step();
        step();
        check("reset_valid", int'(gnt_valid), 0);
        check("reset_idx", int'(gnt_idx), 0);
        check("reset_valid3", int'(v3), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 21; i++) begin
            req = tbl[i].req;
            gnt_ready = tbl[i].rdy;
            step();
            check($sformatf("vec%0d_valid", i), int'(gnt_valid), int'(tbl[i].exp_valid));
            if (tbl[i].exp_valid)
                check($sformatf("vec%0d_idx", i), int'(gnt_idx), int'(tbl[i].exp_idx));
        end

        // Asynchronous reset in the middle of a grant
        req = 4'b1111;
        gnt_ready = 1'b1;
        step();
        check("pre_rst_idx", int'(gnt_idx), 2);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", int'(gnt_valid), 0);
        check("async_rst_idx", int'(gnt_idx), 0);
        @(negedge clk);
        rst_n = 1'b1;
        gnt_ready = 1'b0;
        step();
        check("post_rst_valid", int'(gnt_valid), 1);
        check("post_rst_idx", int'(gnt_idx), 0);

        // Three requesters: wrap must skip index 3
        req = '0;
        gnt_ready = 1'b1;
        step();
        exp3 = '{0, 2, 0, 2};
        req3 = 3'b101;
        rdy3 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("wrap3_%0d_valid", i), int'(v3), 1);
            check($sformatf("wrap3_%0d_idx", i), int'(idx3), exp3[i]);
        end
        req3 = '0;
        step();
        check("wrap3_drain", int'(v3), 0);

`ifdef RR_ARB_GRANT_LOCK_EN
        do_reset();
        req = 4'b0011;
        gnt_ready = 1'b0;
        step();
        check("lock_first", int'(gnt_idx), 0);
        lock = 1'b1;
        gnt_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("lock_hold%0d", i), int'(gnt_idx), 0);
        end
        lock = 1'b0;
        step();
        check("lock_release", int'(gnt_idx), 1);
        req = '0;
        step();
`endif

        // Randomized run against the reference model
        do_reset();
        model_reset();
        for (int c = 0; c < 400; c++) begin
            req = 4'($urandom_range(0, 15));
            gnt_ready = 1'($urandom_range(0, 1));
            req3 = 3'($urandom_range(0, 7));
            rdy3 = 1'($urandom_range(0, 1));
            lk = 1'b0;
`ifdef RR_ARB_GRANT_LOCK_EN
            lk = 1'($urandom_range(0, 1));
            lock = lk;
`endif
            model_step(0, int'(req), gnt_ready, lk);
            model_step(1, int'(req3), rdy3, lk);
            step();
            check("rand_valid", int'(gnt_valid), int'(m_val[0]));
            if (m_val[0]) check("rand_idx", int'(gnt_idx), m_idx[0]);
            check("rand3_valid", int'(v3), int'(m_val[1]));
            if (m_val[1]) check("rand3_idx", int'(idx3), m_idx[1]);
            if (idx3 == 2'd3) check("rand3_range", int'(idx3), 2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
